booth_mac_accum: RTL and testbench
==================================

// Module: booth_mac_accum
// PURPOSE
//  Downstream consumer of booth_multiplier. Accumulates a stream of signed 64-bit products into a wide
//  accumulator and emits one dot-product sum per vector. A vector ends after DOT_LEN products or early on last_i.
//  Uses the same valid/ready handshake on both sides, so it chains directly onto the multiplier res/valid_o/ready_i.
// PARAMETERS
//  PROD_W   64                     width of signed input product
//  ACC_W    72                     width of signed accumulator/output; must be >= PROD_W
//  DOT_LEN  8                      maximum products per vector (>=1)
//  CNT_W    $clog2(DOT_LEN+1)      width of product counter/cnt_o
// PORTS
//  clk      in   1       clock; all logic on posedge
//  rst      in   1       synchronous, active-high reset
//  prod_i   in   PROD_W  signed product from multiplier
//  valid_i  in   1       prod_i valid
//  last_i   in   1       qualifies prod_i: final product of current vector
//  ready_o  out  1       block can accept prod_i this cycle
//  acc_o    out  ACC_W   signed vector sum
//  cnt_o    out  CNT_W   number of products in acc_o (1..DOT_LEN)
//  ovf_o    out  1       overflow occurred in this vector (sticky per vector)
//  valid_o  out  1       acc_o/cnt_o/ovf_o valid
//  ready_i  in   1       downstream accepts output
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=ACC, acc=0, cnt=0, ovf=0, valid_o=0; acc_o=0, cnt_o=0, ovf_o=0.
//  Accept = valid_i & ready_o. Output handshake = valid_o & ready_i.
//  States:
//   ACC:  ready_o=1, valid_o=0. On accept: acc += sext(prod_i), cnt += 1.
//         If last_i=1 or cnt==DOT_LEN-1, go to HOLD with the updated sum. Otherwise stay in ACC.
//   HOLD: valid_o=1; acc_o/cnt_o/ovf_o stay stable until the handshake completes.
//         ready_o=ready_i (combinational pass-through).
//         On handshake with no accept: acc=0, cnt=0, ovf=0, go to ACC.
//         On handshake with simultaneous accept: the new vector starts from zero, so acc=sext(prod_i), cnt=1.
//         Its next state follows the ACC rules (a single-product vector with last_i=1 returns to HOLD).
//  Latency: the sum is on acc_o with valid_o=1 in the cycle after the completing product is accepted.
//  Throughput: one product per cycle, no bubble between vectors while ready_i=1.
//  valid_i with ready_o=0 (HOLD, ready_i=0): the product is not consumed; upstream must hold it.
//  Output stays stable under backpressure for any number of cycles.
//  valid_o does not depend combinationally on valid_i.
//  last_i is ignored when valid_i=0.
//  Sign extension: prod_i is sign-extended to ACC_W before the add.
//  cnt never exceeds DOT_LEN.
//  A rst pulse mid-vector or during HOLD discards the partial/held sum; the next cycle is the reset state.
// CONFIGURATION
//  MAC_SAT_EN defined:
//   - The add is computed at ACC_W+1 bits.
//   - On signed overflow, acc clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and ovf is set.
//   - Once saturated, later adds in the same vector continue from the clamped value.
//  MAC_SAT_EN undefined:
//   - acc wraps modulo 2^ACC_W (two's complement).
//   - ovf is set on signed overflow of the add but does not alter acc.
//  ovf_o clears only on output handshake or rst in both builds.
// TESTING
//  1 DOT_LEN=8, ready_i=1, 8 back-to-back products 1..8, last_i=0 -> one output: acc_o=36, cnt_o=8, ovf_o=0, 1 cycle after 8th accept.
//  2 3 products (-5, 7, -100) with last_i on 3rd -> acc_o=-98, cnt_o=3; next vector of single product 42 with last_i=1 accepted in handshake cycle -> acc_o=42, cnt_o=1, no bubble.
//  3 ready_i=0 for 10 cycles while HOLD -> ready_o=0, acc_o/cnt_o stable; valid_i held, no product lost; after release next vector sums correctly.
//  4 ACC_W=64, two products 0x7FFF_FFFF_FFFF_FFFF then 1, last_i on 2nd:
//    with MAC_SAT_EN -> acc_o=0x7FFF_FFFF_FFFF_FFFF, ovf_o=1;
//    without MAC_SAT_EN -> acc_o=0x8000_0000_0000_0000, ovf_o=1.
//  5 rst=1 for one cycle after 4 of 8 products, then 8 products of value 2 -> acc_o=16, cnt_o=8 (partial sum discarded); all outputs 0 during reset.
//  6 Chained to booth_multiplier, 10000 random 32x32 signed operand pairs, DOT_LEN=8, random ready_i -> every acc_o equals reference sum of $signed(A)*$signed(B).

Source files
------------

// File: rtl/booth_mac_accum.sv
// booth_mac_accum: sums a valid/ready stream of signed products into one dot-product result per vector.
// Optional build macro MAC_SAT_EN: saturate the accumulator on signed overflow instead of wrapping.
module booth_mac_accum #(
  parameter int PROD_W  = 64,
  parameter int ACC_W   = 72,
  parameter int DOT_LEN = 8,
  parameter int CNT_W   = $clog2(DOT_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              valid_i,
  input  logic              last_i,
  output logic              ready_o,
  output logic [ACC_W-1:0]  acc_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              ovf_o,
  output logic              valid_o,
  input  logic              ready_i
);

  typedef enum logic [0:0] {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_e;

`ifdef MAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOT_LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             accept_s;
  logic             hs_s;
  logic [ACC_W-1:0] base_acc_s;
  logic [CNT_W-1:0] base_cnt_s;
  logic             base_ovf_s;
  logic [ACC_W:0]   sum_s;
  logic             add_ovf_s;
  logic [ACC_W-1:0] add_res_s;

  assign valid_o  = (state_q == ST_HOLD);
  assign acc_o    = acc_q;
  assign cnt_o    = cnt_q;
  assign ovf_o    = ovf_q;
  assign accept_s = valid_i & ready_o;
  assign hs_s     = valid_o & ready_i;

  // Downstream ready passes straight through in HOLD so a new vector can start in the drain cycle.
  always_comb begin
    ready_o = 1'b1;
    if (state_q == ST_HOLD) begin
      ready_o = ready_i;
    end else begin
      ready_o = 1'b1;
    end
  end

  // Adder operand base is zero when the held result drains this same cycle; overflow from a one-bit-wider add.
  always_comb begin
    base_acc_s = acc_q;
    base_cnt_s = cnt_q;
    base_ovf_s = ovf_q;
    if (hs_s) begin
      base_acc_s = {ACC_W{1'b0}};
      base_cnt_s = {CNT_W{1'b0}};
      base_ovf_s = 1'b0;
    end else begin
      base_acc_s = acc_q;
      base_cnt_s = cnt_q;
      base_ovf_s = ovf_q;
    end
    sum_s     = {base_acc_s[ACC_W-1], base_acc_s}
              + {{(ACC_W + 1 - PROD_W){prod_i[PROD_W-1]}}, prod_i};
    add_ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
`ifdef MAC_SAT_EN
    if (add_ovf_s) begin
      add_res_s = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      add_res_s = sum_s[ACC_W-1:0];
    end
`else
    add_res_s = sum_s[ACC_W-1:0];
`endif
  end

  // Next-state: accept extends the vector, a bare handshake clears it and returns to ACC.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (accept_s) begin
      acc_d = add_res_s;
      cnt_d = base_cnt_s + {{(CNT_W-1){1'b0}}, 1'b1};
      ovf_d = base_ovf_s | add_ovf_s;
      if (last_i || (base_cnt_s == CNT_LAST)) begin
        state_d = ST_HOLD;
      end else begin
        state_d = ST_ACC;
      end
    end else if (hs_s) begin
      acc_d   = {ACC_W{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
      ovf_d   = 1'b0;
      state_d = ST_ACC;
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= {ACC_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_booth_mac_accum.sv
// Self-checking bench for booth_mac_accum: directed scenarios plus a randomized stream against a sum model.
`timescale 1ns/1ps
module tb_booth_mac_accum;
  localparam int PROD_W  = 64;
  localparam int ACC_W   = 72;
  localparam int DOT_LEN = 8;
  localparam int CNT_W   = $clog2(DOT_LEN + 1);
  localparam int N_RAND  = 10000;
  localparam int CYC_MAX = 60000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PROD_W-1:0] prod_i = 64'd0;
  logic              valid_i = 1'b0;
  logic              last_i = 1'b0;
  logic              ready_i = 1'b1;
  logic              ready_o, valid_o, ovf_o;
  logic [ACC_W-1:0]  acc_o;
  logic [CNT_W-1:0]  cnt_o;
  logic              ready64_o, valid64_o, ovf64_o;
  logic [63:0]       acc64_o;
  logic [CNT_W-1:0]  cnt64_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [ACC_W-1:0] acc;
    int               cnt;
    logic             ovf;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  booth_mac_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .DOT_LEN(DOT_LEN)) dut (
    .clk(clk), .rst(rst), .prod_i(prod_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_o), .acc_o(acc_o), .cnt_o(cnt_o), .ovf_o(ovf_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  booth_mac_accum #(.PROD_W(64), .ACC_W(64), .DOT_LEN(DOT_LEN)) dut64 (
    .clk(clk), .rst(rst), .prod_i(prod_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready64_o), .acc_o(acc64_o), .cnt_o(cnt64_o), .ovf_o(ovf64_o),
    .valid_o(valid64_o), .ready_i(ready_i)
  );

  task automatic cyc(input logic v, input logic [63:0] p, input logic l, input logic r);
    @(negedge clk);
    rst = 1'b0; valid_i = v; prod_i = p; last_i = l; ready_i = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (acc_o !== 72'd0) begin bad++; $display("FAIL reset_acc: got %0h want 0", acc_o); end
    total++; if (cnt_o !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", cnt_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_full_vector();
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 64'(k), 1'b0, 1'b1);
      if (k == 7) begin
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL full_early_valid: got %b want 0", valid_o); end
      end
    end
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL full_valid: got %b want 1", valid_o); end
    total++; if (acc_o !== 72'd36) begin bad++; $display("FAIL full_acc: got %0d want 36", acc_o); end
    total++; if (cnt_o !== 4'd8) begin bad++; $display("FAIL full_cnt: got %0d want 8", cnt_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL full_ovf: got %b want 0", ovf_o); end
  endtask

  task automatic test_back_to_back();
    logic [ACC_W-1:0] e;
    cyc(1'b1, -64'sd5, 1'b0, 1'b1);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL b2b_drain_valid: got %b want 0", valid_o); end
    cyc(1'b1, 64'sd7, 1'b0, 1'b1);
    cyc(1'b1, -64'sd100, 1'b1, 1'b1);
    e = -72'sd98;
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", valid_o); end
    total++; if (acc_o !== e) begin bad++; $display("FAIL b2b_acc: got %0h want %0h", acc_o, e); end
    total++; if (cnt_o !== 4'd3) begin bad++; $display("FAIL b2b_cnt: got %0d want 3", cnt_o); end
    cyc(1'b1, 64'sd42, 1'b1, 1'b1);
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL b2b_single_valid: got %b want 1", valid_o); end
    total++; if (acc_o !== 72'd42) begin bad++; $display("FAIL b2b_single_acc: got %0d want 42", acc_o); end
    total++; if (cnt_o !== 4'd1) begin bad++; $display("FAIL b2b_single_cnt: got %0d want 1", cnt_o); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 64'd9, 1'b1, 1'b0);
      total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, ready_o); end
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, valid_o); end
      total++; if (acc_o !== 72'd42) begin bad++; $display("FAIL bp_acc[%0d]: got %0d want 42", i, acc_o); end
      total++; if (cnt_o !== 4'd1) begin bad++; $display("FAIL bp_cnt[%0d]: got %0d want 1", i, cnt_o); end
    end
    cyc(1'b1, 64'd9, 1'b1, 1'b1);
    total++; if (acc_o !== 72'd9) begin bad++; $display("FAIL bp_held_acc: got %0d want 9", acc_o); end
    total++; if (cnt_o !== 4'd1) begin bad++; $display("FAIL bp_held_cnt: got %0d want 1", cnt_o); end
    cyc(1'b0, 64'd0, 1'b0, 1'b1);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL bp_idle_valid: got %b want 0", valid_o); end
    total++; if (acc_o !== 72'd0) begin bad++; $display("FAIL bp_idle_acc: got %0d want 0", acc_o); end
    total++; if (cnt_o !== 4'd0) begin bad++; $display("FAIL bp_idle_cnt: got %0d want 0", cnt_o); end
    cyc(1'b1, 64'd3, 1'b0, 1'b1);
    cyc(1'b1, 64'd4, 1'b1, 1'b1);
    total++; if (acc_o !== 72'd7) begin bad++; $display("FAIL bp_next_acc: got %0d want 7", acc_o); end
    total++; if (cnt_o !== 4'd2) begin bad++; $display("FAIL bp_next_cnt: got %0d want 2", cnt_o); end
  endtask

  task automatic test_overflow();
    logic [63:0] e_pos, e_neg, e_cont;
`ifdef MAC_SAT_EN
    e_pos = 64'h7FFF_FFFF_FFFF_FFFF; e_neg = 64'h8000_0000_0000_0000; e_cont = 64'h7FFF_FFFF_FFFF_FFFE;
`else
    e_pos = 64'h8000_0000_0000_0000; e_neg = 64'h7FFF_FFFF_FFFF_FFFF; e_cont = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    do_reset();
    cyc(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    cyc(1'b1, 64'd1, 1'b1, 1'b1);
    total++; if (valid64_o !== 1'b1) begin bad++; $display("FAIL ovf_pos_valid: got %b want 1", valid64_o); end
    total++; if (acc64_o !== e_pos) begin bad++; $display("FAIL ovf_pos_acc: got %0h want %0h", acc64_o, e_pos); end
    total++; if (ovf64_o !== 1'b1) begin bad++; $display("FAIL ovf_pos_flag: got %b want 1", ovf64_o); end
    total++; if (acc_o !== 72'h00_8000_0000_0000_0000) begin bad++; $display("FAIL ovf_wide_acc: got %0h want 8000000000000000", acc_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_wide_flag: got %b want 0", ovf_o); end
    cyc(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    total++; if (acc64_o !== e_neg) begin bad++; $display("FAIL ovf_neg_acc: got %0h want %0h", acc64_o, e_neg); end
    total++; if (ovf64_o !== 1'b1) begin bad++; $display("FAIL ovf_neg_flag: got %b want 1", ovf64_o); end
    total++; if (acc_o !== 72'hFF_7FFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL ovf_wide_neg_acc: got %0h want ff7fffffffffffffff", acc_o); end
    cyc(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    cyc(1'b1, 64'd1, 1'b0, 1'b1);
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    total++; if (acc64_o !== e_cont) begin bad++; $display("FAIL ovf_cont_acc: got %0h want %0h", acc64_o, e_cont); end
    total++; if (ovf64_o !== 1'b1) begin bad++; $display("FAIL ovf_cont_sticky: got %b want 1", ovf64_o); end
    total++; if (cnt64_o !== 4'd3) begin bad++; $display("FAIL ovf_cont_cnt: got %0d want 3", cnt64_o); end
    cyc(1'b0, 64'd0, 1'b0, 1'b1);
    total++; if (ovf64_o !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", ovf64_o); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cyc(1'b1, 64'd5, 1'b0, 1'b1);
    do_reset();
    total++; if (acc_o !== 72'd0) begin bad++; $display("FAIL rmid_acc: got %0d want 0", acc_o); end
    total++; if (cnt_o !== 4'd0) begin bad++; $display("FAIL rmid_cnt: got %0d want 0", cnt_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", valid_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL rmid_ovf: got %b want 0", ovf_o); end
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'd2, 1'b0, 1'b1);
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL rmid_after_valid: got %b want 1", valid_o); end
    total++; if (acc_o !== 72'd16) begin bad++; $display("FAIL rmid_after_acc: got %0d want 16", acc_o); end
    total++; if (cnt_o !== 4'd8) begin bad++; $display("FAIL rmid_after_cnt: got %0d want 8", cnt_o); end
    cyc(1'b0, 64'd0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int                       a, b, n_acc, cyc_n, m_cnt;
    logic                     keep, v, l, hold_e, acc_e, m_ovf;
    longint                   p;
    logic signed [ACC_W-1:0]  m_acc;
    logic signed [ACC_W+7:0]  exact, maxv, minv;
    exp_t                     e;
    maxv = (80'sd1 <<< (ACC_W - 1)) - 80'sd1;
    minv = -(80'sd1 <<< (ACC_W - 1));
    n_acc = 0; cyc_n = 0; keep = 1'b0; v = 1'b0; l = 1'b0; a = 0; b = 0;
    m_acc = '0; m_cnt = 0; m_ovf = 1'b0;
    exp_q.delete();
    while (n_acc < N_RAND && cyc_n < CYC_MAX) begin
      @(negedge clk);
      if (!keep) begin
        a = $urandom; b = $urandom;
        v = ($urandom_range(0, 9) < 8);
        l = ($urandom_range(0, 4) == 0);
      end
      p = longint'(a) * longint'(b);
      rst = 1'b0; valid_i = v; prod_i = p; last_i = l;
      ready_i = ($urandom_range(0, 9) < 7);
      #1;
      hold_e = (exp_q.size() != 0);
      total++; if (valid_o !== hold_e) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc_n, valid_o, hold_e); end
      total++; if (ready_o !== (hold_e ? ready_i : 1'b1)) begin bad++; $display("FAIL rnd_ready@%0d: got %b", cyc_n, ready_o); end
      if (hold_e && ready_i) begin
        e = exp_q.pop_front();
        total++; if (acc_o !== e.acc) begin bad++; $display("FAIL rnd_acc@%0d: got %0h want %0h", cyc_n, acc_o, e.acc); end
        total++; if (int'(cnt_o) !== e.cnt) begin bad++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", cyc_n, cnt_o, e.cnt); end
        total++; if (ovf_o !== e.ovf) begin bad++; $display("FAIL rnd_ovf@%0d: got %b want %b", cyc_n, ovf_o, e.ovf); end
      end
      acc_e = v && (!hold_e || ready_i);
      if (acc_e) begin
        exact = m_acc;
        exact = exact + p;
        if (exact > maxv || exact < minv) begin
          m_ovf = 1'b1;
`ifdef MAC_SAT_EN
          m_acc = (exact > maxv) ? maxv[ACC_W-1:0] : minv[ACC_W-1:0];
`else
          m_acc = exact[ACC_W-1:0];
`endif
        end else begin
          m_acc = exact[ACC_W-1:0];
        end
        m_cnt++; n_acc++;
        if (l || m_cnt == DOT_LEN) begin
          exp_q.push_back('{m_acc, m_cnt, m_ovf});
          m_acc = '0; m_cnt = 0; m_ovf = 1'b0;
        end
      end
      keep = v && !acc_e;
      cyc_n++;
    end
    total++; if (n_acc < N_RAND) begin bad++; $display("FAIL rnd_budget: accepted %0d want %0d", n_acc, N_RAND); end
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b1;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++; if (acc_o !== e.acc) begin bad++; $display("FAIL rnd_tail_acc: got %0h want %0h", acc_o, e.acc); end
      total++; if (int'(cnt_o) !== e.cnt) begin bad++; $display("FAIL rnd_tail_cnt: got %0d want %0d", cnt_o, e.cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
